// File: rtl/fft_r3_pkg.sv
// Shared types for the radix-3^2 FFT pipeline stages.
//   W_DEF  : default component width (IEEE-754 single, opaque bits)
//   cplx_t : packed {re, im} complex sample at the default width
//   seg_t  : input-reordering phase of a 3*D-sample block
package fft_r3_pkg;
  localparam int W_DEF = 32;

  typedef struct packed {
    logic [W_DEF-1:0] re;
    logic [W_DEF-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    FILL_A = 2'd0,
    FILL_B = 2'd1,
    EMIT   = 2'd2
  } seg_t;
endpackage

// File: rtl/r3_seg_store.sv
// r3_seg_store: D-deep segment buffer holding one D-sample segment of a block.
//   clk    : rising-edge clock
//   we     : write enable
//   waddr  : write index
//   wdata  : {re, im} sample to store
//   raddr  : read index (asynchronous read)
//   rdata  : {re, im} sample at raddr
// Contents are intentionally not reset; every location is written before it is read.
module r3_seg_store #(
  parameter int W  = 32,
  parameter int D  = 3,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [2*W-1:0] wdata,
  input  logic [IW-1:0] raddr,
  output logic [2*W-1:0] rdata
);
  logic [2*W-1:0] mem [D];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/r3_triplet_align.sv
// r3_triplet_align: input-reordering stage ahead of the radix-3 butterfly.
// Buffers segments A (x[0..D-1]) and B (x[D..2D-1]) of each 3*D block, then,
// while segment C streams in, emits {A[n], B[n], x[n+2D]} one triplet per input.
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : input handshake; in_re/in_im sample
//   out_valid/out_ready   : output handshake; x0_* = x[n], x1_* = x[n+D], x2_* = x[n+2D]
//   out_last              : only when R3_LAST_EN is defined; marks final triplet of a block
module r3_triplet_align
  import fft_r3_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int D = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_re,
  input  logic [W-1:0] in_im,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] x0_re,
  output logic [W-1:0] x0_im,
  output logic [W-1:0] x1_re,
  output logic [W-1:0] x1_im,
  output logic [W-1:0] x2_re,
  output logic [W-1:0] x2_im
`ifdef R3_LAST_EN
  ,
  output logic         out_last
`endif
);
  localparam int            IW       = (D > 1) ? $clog2(D) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(D - 1);

  seg_t          seg;
  logic [IW-1:0] idx;
  logic          in_fire, out_fire, idx_wrap;
  logic          we_a, we_b;
  logic [2*W-1:0] a_rd, b_rd, in_pk;

  // Single output register with no skid: in EMIT, input is taken only when the
  // register is empty or draining this cycle. FILL phases never touch it.
  assign in_ready = (seg != EMIT) | ~out_valid | out_ready;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign idx_wrap = (idx == IDX_LAST);
  assign in_pk    = {in_re, in_im};

  // FILL_A of the next block may run while a triplet is held; it only rewrites
  // A locations whose triplets have already been captured in the output register.
  assign we_a = in_fire & (seg == FILL_A);
  assign we_b = in_fire & (seg == FILL_B);

  r3_seg_store #(.W(W), .D(D), .IW(IW)) u_seg_a (
    .clk(clk), .we(we_a), .waddr(idx), .wdata(in_pk), .raddr(idx), .rdata(a_rd)
  );

  r3_seg_store #(.W(W), .D(D), .IW(IW)) u_seg_b (
    .clk(clk), .we(we_b), .waddr(idx), .wdata(in_pk), .raddr(idx), .rdata(b_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= FILL_A;
      idx <= '0;
    end else if (in_fire) begin
      idx <= idx_wrap ? '0 : idx + IW'(1);
      if (idx_wrap) begin
        case (seg)
          FILL_A:  seg <= FILL_B;
          FILL_B:  seg <= EMIT;
          default: seg <= FILL_A;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      x0_re <= '0; x0_im <= '0;
      x1_re <= '0; x1_im <= '0;
      x2_re <= '0; x2_im <= '0;
`ifdef R3_LAST_EN
      out_last <= 1'b0;
`endif
    end else if (in_fire && seg == EMIT) begin
      // Reload wins over drain: a same-cycle output transfer keeps out_valid high.
      out_valid <= 1'b1;
      {x0_re, x0_im} <= a_rd;
      {x1_re, x1_im} <= b_rd;
      {x2_re, x2_im} <= in_pk;
`ifdef R3_LAST_EN
      out_last <= idx_wrap;
`endif
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_r3_triplet_align.sv
// Directed bench for r3_triplet_align: a D=3 instance (u3) and a D=1 instance (u1).
// Samples use re=v, im=0x100+v; expected triplets are built from the sample values.
// out_last checks are compiled only when R3_LAST_EN is defined.
module tb_r3_triplet_align;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        in_valid3 = 0, in_valid1 = 0;
  logic [31:0] in_re3 = 0, in_im3 = 0, in_re1 = 0, in_im1 = 0;
  logic        out_ready3 = 1, out_ready1 = 1;
  logic        in_ready3, in_ready1, out_valid3, out_valid1;
  logic [31:0] a0r, a0i, a1r, a1i, a2r, a2i;
  logic [31:0] b0r, b0i, b1r, b1i, b2r, b2i;
  logic        last3, last1;

  int errs = 0, checks = 0, cyc = 0;
  int t_first = 0, ir_low = 0;
  bit mon_ir = 0;
  logic [191:0] q3[$], q1[$];
  int           q3_cyc[$];
  logic         q3_last[$], q1_last[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  r3_triplet_align #(.W(32), .D(3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_re(in_re3), .in_im(in_im3), .out_valid(out_valid3), .out_ready(out_ready3),
    .x0_re(a0r), .x0_im(a0i), .x1_re(a1r), .x1_im(a1i), .x2_re(a2r), .x2_im(a2i)
`ifdef R3_LAST_EN
    , .out_last(last3)
`endif
  );

  r3_triplet_align #(.W(32), .D(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_re(in_re1), .in_im(in_im1), .out_valid(out_valid1), .out_ready(out_ready1),
    .x0_re(b0r), .x0_im(b0i), .x1_re(b1r), .x1_im(b1i), .x2_re(b2r), .x2_im(b2i)
`ifdef R3_LAST_EN
    , .out_last(last1)
`endif
  );

`ifndef R3_LAST_EN
  assign last3 = 1'b0;
  assign last1 = 1'b0;
`endif

  // Record every output transfer away from the active edge.
  always @(negedge clk) begin
    if (out_valid3 && out_ready3) begin
      q3.push_back({a0r, a1r, a2r, a0i, a1i, a2i});
      q3_cyc.push_back(cyc);
      q3_last.push_back(last3);
    end
    if (out_valid1 && out_ready1) begin
      q1.push_back({b0r, b1r, b2r, b0i, b1i, b2i});
      q1_last.push_back(last1);
    end
    if (mon_ir && !in_ready3) ir_low <= ir_low + 1;
  end

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [191:0] trip(input int a, input int b, input int c);
    return {32'(a), 32'(b), 32'(c), 32'(256 + a), 32'(256 + b), 32'(256 + c)};
  endfunction

  task automatic send(input bit which, input int v);
    bit acc = 0;
    int n = 0;
    if (which) begin in_valid1 = 1; in_re1 = v; in_im1 = 256 + v; end
    else       begin in_valid3 = 1; in_re3 = v; in_im3 = 256 + v; end
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = which ? in_ready1 : in_ready3;
      @(posedge clk); #1;
      n++;
    end
    in_valid1 = 0;
    in_valid3 = 0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // D=3 stream of consecutive values from v0: block j yields (v+k, v+3+k, v+6+k).
  task automatic chk_d3(input string tag, input int v0, input int nblk);
    int v;
    chk({tag, "_count"}, q3.size(), 3 * nblk);
    for (int i = 0; i < 3 * nblk && i < q3.size(); i++) begin
      v = v0 + 9 * (i / 3) + (i % 3);
      chk($sformatf("%s_trip%0d", tag, i), q3[i], trip(v, v + 3, v + 6));
    end
  endtask

  task automatic clr();
    q3.delete(); q3_cyc.delete(); q3_last.delete();
    q1.delete(); q1_last.delete();
  endtask

  initial begin
    // Reset state
    idle(2);
    @(negedge clk);
    chk("rst_out_valid", out_valid3, 0);
    chk("rst_x0_re", a0r, 0);
    chk("rst_x2_im", a2i, 0);
    chk("rst_in_ready", in_ready3, 1);
    @(posedge clk); #1;
    rst_n = 1;
    idle(1);

    // 1: one block back-to-back, out_ready=1
    clr();
    mon_ir = 1;
    send(0, 1);
    t_first = cyc;
    for (int v = 2; v <= 9; v++) send(0, v);
    idle(3);
    mon_ir = 0;
    chk_d3("t1", 1, 1);
    for (int k = 0; k < 3 && k < q3_cyc.size(); k++)
      chk($sformatf("t1_cycle%0d", k), q3_cyc[k] - t_first + 1, 7 + k);
    chk("t1_in_ready_low", ir_low, 0);
`ifdef R3_LAST_EN
    for (int k = 0; k < 3 && k < q3_last.size(); k++)
      chk($sformatf("t1_last%0d", k), q3_last[k], k == 2);
`endif

    // 2: back-pressure during EMIT
    clr();
    out_ready3 = 0;
    for (int v = 1; v <= 7; v++) send(0, v);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("t2_hold_in_ready%0d", k), in_ready3, 0);
      chk($sformatf("t2_hold_valid%0d", k), out_valid3, 1);
      chk($sformatf("t2_hold_trip%0d", k), {a0r, a1r, a2r, a0i, a1i, a2i}, trip(1, 4, 7));
    end
    @(posedge clk); #1;
    out_ready3 = 1;
    send(0, 8);
    send(0, 9);
    idle(3);
    chk_d3("t2", 1, 1);

    // 3: in_valid toggled every cycle, two blocks
    clr();
    for (int v = 21; v <= 38; v++) begin
      send(0, v);
      idle(1);
    end
    idle(2);
    chk_d3("t3", 21, 2);

    // 4: reset mid-block discards the partial block
    clr();
    for (int v = 41; v <= 45; v++) send(0, v);
    rst_n = 0;
    @(negedge clk);
    chk("t4_rst_valid", out_valid3, 0);
    chk("t4_rst_in_ready", in_ready3, 1);
    @(posedge clk); #1;
    rst_n = 1;
    idle(1);
    for (int v = 11; v <= 19; v++) send(0, v);
    idle(3);
    chk_d3("t4", 11, 1);

    // 5: D=1, every sample advances the phase
    clr();
    for (int v = 1; v <= 6; v++) send(1, v);
    idle(3);
    chk("t5_count", q1.size(), 2);
    if (q1.size() > 0) chk("t5_trip0", q1[0], trip(1, 2, 3));
    if (q1.size() > 1) chk("t5_trip1", q1[1], trip(4, 5, 6));
`ifdef R3_LAST_EN
    for (int k = 0; k < 2 && k < q1_last.size(); k++)
      chk($sformatf("t5_last%0d", k), q1_last[k], 1);
`endif

    // 6: three continuous blocks; FILL_A of the next block follows EMIT directly
    clr();
    for (int v = 51; v <= 77; v++) send(0, v);
    idle(3);
    chk_d3("t6", 51, 3);
    for (int k = 0; k < 9 && k + 1 < q3_cyc.size(); k++)
      if (k % 3 != 2) chk($sformatf("t6_gap%0d", k), q3_cyc[k + 1] - q3_cyc[k], 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=0", cyc);
    $fatal(1, "timeout");
  end
endmodule
